dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_addr_check.sv | 24 ++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: state encoding, defaults
// and counter sizing.
package dmem_pkg;

   localparam int unsigned DEF_DEPTH_WORDS = 128;
   localparam int unsigned DEF_LATENCY     = 2;
   localparam int unsigned CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational request validation: flags misaligned, out-of-range and
// read+write requests, and extracts the word index.
module dmem_addr_check
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
   input  logic [31:0]                      addr,
   input  logic                             mem_read,
   input  logic                             mem_write,
   output logic                             err_c,
   output logic [$clog2(DEPTH_WORDS)-1:0]   word_idx_c
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   always_comb begin
      err_c      = (addr[1:0] != 2'd0)
                || (addr[31:2] >= 30'(DEPTH_WORDS))
                || (mem_read && mem_write);
      word_idx_c = addr[IDX_W+1:2];
   end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data memory: accepts one load/store in IDLE, waits LATENCY
// cycles, then commits and issues a single-cycle response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int unsigned LATENCY     = DEF_LATENCY
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic        resp_valid_o,
   output logic [31:0] data_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               accept_c;
   logic               commit_c;

   logic [31:0]        req_addr;
   logic [31:0]        req_data;
   logic               req_rd;
   logic               req_wr;

   logic               err_c;
   logic [IDX_W-1:0]   word_idx_c;

   logic [31:0]        mem [DEPTH_WORDS];

   dmem_addr_check #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_addr_check (
      .addr       (req_addr),
      .mem_read   (req_rd),
      .mem_write  (req_wr),
      .err_c      (err_c),
      .word_idx_c (word_idx_c)
   );

   // Next-state and counter logic; commit_c marks the WAIT->RESP edge.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      accept_c   = 1'b0;
      commit_c   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid_i && (MemRead_i || MemWrite_i)) begin
               state_next = WAIT;
               cnt_next   = CNT_W'(LATENCY - 1);
               accept_c   = 1'b1;
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(0)) begin
               state_next = RESP;
               commit_c   = 1'b1;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         resp_valid_o <= 1'b0;
         err_o        <= 1'b0;
         data_o       <= '0;
         busy_o       <= 1'b0;
         req_ready_o  <= 1'b1;
         req_addr     <= '0;
         req_data     <= '0;
         req_rd       <= 1'b0;
         req_wr       <= 1'b0;
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            mem[IDX_W'(i)] <= '0;
         end
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         resp_valid_o <= commit_c;
         err_o        <= commit_c && err_c;
         busy_o       <= (state_next != IDLE);
         req_ready_o  <= (state_next == IDLE);
         if (accept_c) begin
            req_addr <= addr_i;
            req_data <= data_i;
            req_rd   <= MemRead_i;
            req_wr   <= MemWrite_i;
         end
         // Loads return the pre-commit word; stores and errors return zero.
         if (commit_c) begin
            data_o <= (!err_c && req_rd) ? mem[word_idx_c] : 32'd0;
            if (!err_c && req_wr) begin
               mem[word_idx_c] <= req_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=128, LATENCY=2).
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic        resp_valid_o;
   logic [31:0] data_o;
   logic        err_o;
   logic        busy_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS (128),
      .LATENCY     (2)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .MemRead_i    (MemRead_i),
      .MemWrite_i   (MemWrite_i),
      .addr_i       (addr_i),
      .data_i       (data_i),
      .resp_valid_o (resp_valid_o),
      .data_o       (data_o),
      .err_o        (err_o),
      .busy_o       (busy_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request from IDLE and wait for its response; returns the number
   // of falling edges after the accept edge at which resp_valid_o was seen.
   task automatic send(input string tag, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input bit scramble,
                       output int lat, output logic [31:0] dout, output logic eout);
      @(negedge clk);
      check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1;
      MemRead_i   = rd;
      MemWrite_i  = wr;
      addr_i      = a;
      data_i      = d;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      lat  = 0;
      dout = 'x;
      eout = 1'bx;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (resp_valid_o) begin
            lat  = n;
            dout = data_o;
            eout = err_o;
            break;
         end
         if (scramble) begin
            addr_i     = $urandom;
            data_i     = $urandom;
            MemRead_i  = 1'($urandom);
            MemWrite_i = 1'($urandom);
         end
      end
   endtask

   int          lat;
   logic [31:0] dout;
   logic        eout;
   int          p;
   logic [31:0] exp_d;

   initial begin
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      MemRead_i   = 1'b0;
      MemWrite_i  = 1'b0;
      addr_i      = '0;
      data_i      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
      check("rst_err",        32'(err_o),        32'd0);
      check("rst_data",       data_o,            32'd0);
      check("rst_busy",       32'(busy_o),       32'd0);
      check("rst_ready",      32'(req_ready_o),  32'd1);
      rst_i = 1'b0;

      // Basic store then load
      send("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, dout, eout);
      check("st10_lat",  32'(lat),  32'd3);
      check("st10_err",  32'(eout), 32'd0);
      check("st10_data", dout,      32'd0);
      send("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, dout, eout);
      check("ld10_lat",  32'(lat),  32'd3);
      check("ld10_err",  32'(eout), 32'd0);
      check("ld10_data", dout,      32'hDEADBEEF);
      @(negedge clk);
      check("hold_data",  data_o,            32'hDEADBEEF);
      check("hold_valid", 32'(resp_valid_o), 32'd0);
      check("hold_err",   32'(err_o),        32'd0);

      // Error cases
      send("ld12", 1'b1, 1'b0, 32'h12, 32'h0, 1'b0, lat, dout, eout);
      check("ld12_err",  32'(eout), 32'd1);
      check("ld12_data", dout,      32'd0);
      send("ld200", 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, lat, dout, eout);
      check("ld200_lat",  32'(lat),  32'd3);
      check("ld200_err",  32'(eout), 32'd1);
      check("ld200_data", dout,      32'd0);
      send("ld1fc", 1'b1, 1'b0, 32'h1FC, 32'h0, 1'b0, lat, dout, eout);
      check("ld1fc_err",  32'(eout), 32'd0);
      check("ld1fc_data", dout,      32'd0);
      send("rw10", 1'b1, 1'b1, 32'h10, 32'h11111111, 1'b0, lat, dout, eout);
      check("rw10_err",  32'(eout), 32'd1);
      check("rw10_data", dout,      32'd0);
      send("ld10b", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, dout, eout);
      check("ld10b_err",  32'(eout), 32'd0);
      check("ld10b_data", dout,      32'hDEADBEEF);

      // Request with neither op bit is ignored
      @(negedge clk);
      req_valid_i = 1'b1;
      MemRead_i   = 1'b0;
      MemWrite_i  = 1'b0;
      addr_i      = 32'h10;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("noop_busy",  32'(busy_o),       32'd0);
         check("noop_resp",  32'(resp_valid_o), 32'd0);
         check("noop_ready", 32'(req_ready_o),  32'd1);
      end
      req_valid_i = 1'b0;

      // Back-to-back with req_valid_i held high: one response every 4 cycles
      p = 0;
      exp_d = 32'd0;
      req_valid_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) @(negedge clk);
         check("b2b_ready", 32'(req_ready_o),  (p == 0) ? 32'd1 : 32'd0);
         check("b2b_resp",  32'(resp_valid_o), (p == 3) ? 32'd1 : 32'd0);
         if (p == 0) begin
            case (i / 4)
               0: begin MemRead_i = 1'b0; MemWrite_i = 1'b1; addr_i = 32'h0; data_i = 32'h0BADF00D; exp_d = 32'h0; end
               1: begin MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h0; data_i = 32'h0;        exp_d = 32'h0BADF00D; end
               2: begin MemRead_i = 1'b0; MemWrite_i = 1'b1; addr_i = 32'h4; data_i = 32'hCAFEF00D; exp_d = 32'h0; end
               default: begin MemRead_i = 1'b1; MemWrite_i = 1'b0; addr_i = 32'h4; data_i = 32'h0; exp_d = 32'hCAFEF00D; end
            endcase
         end
         if (p == 3) begin
            check("b2b_data", data_o,      exp_d);
            check("b2b_err",  32'(err_o),  32'd0);
         end
         p = (p + 1) % 4;
      end
      req_valid_i = 1'b0;

      // Reset during the second WAIT cycle aborts the store
      @(negedge clk);
      req_valid_i = 1'b1;
      MemRead_i   = 1'b0;
      MemWrite_i  = 1'b1;
      addr_i      = 32'h8;
      data_i      = 32'h12345678;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy_o), 32'd1);
      @(negedge clk);
      rst_i       = 1'b1;
      req_valid_i = 1'b1;
      MemRead_i   = 1'b1;
      MemWrite_i  = 1'b0;
      addr_i      = 32'h0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("abort_resp", 32'(resp_valid_o), 32'd0);
      end
      rst_i       = 1'b0;
      req_valid_i = 1'b0;
      check("abort_busy_rst", 32'(busy_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_resp_after", 32'(resp_valid_o), 32'd0);
      end
      send("ld8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, lat, dout, eout);
      check("ld8_lat",  32'(lat),  32'd3);
      check("ld8_data", dout,      32'd0);
      send("ld10c", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, dout, eout);
      check("ld10c_data", dout, 32'd0);

      // Inputs changing during WAIT do not disturb the latched request
      send("st20", 1'b0, 1'b1, 32'h20, 32'h55AA55AA, 1'b1, lat, dout, eout);
      check("st20_lat",  32'(lat),  32'd3);
      check("st20_err",  32'(eout), 32'd0);
      check("st20_data", dout,      32'd0);
      send("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, lat, dout, eout);
      check("ld20_lat",  32'(lat),  32'd3);
      check("ld20_err",  32'(eout), 32'd0);
      check("ld20_data", dout,      32'h55AA55AA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
